iic_eeprom_slave: RTL
=====================

# iic_eeprom_slave

I2C responder that models a 256-byte, 8-bit-address serial EEPROM on the board-level `iic_scl`/`iic_sda` bus. It is the bus target for the team's I2C master (write and random-read sequences). It is used in simulation and as an on-FPGA loopback target. Supported transactions are byte/sequential write, random read, current-address read and sequential read, with open-drain SDA drive and a write-strobe side port for monitoring.

## Interface
- `DEV_ADDR`, default 7'b101_0000: 7-bit device address matched in the first byte.
- `sys_clk`  in  1  system clock, 100 MHz; one clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `iic_scl`  in  1  bus clock from the master, asynchronous to `sys_clk`.
- `iic_sda`  inout  1  open-drain: driven 0 when `sda_oe`=1, else `1'bz`. Never driven 1.
- `o_wr_en`  out  1  one-cycle pulse per committed write byte.
- `o_wr_addr`  out  8  memory address of the committed byte.
- `o_wr_dat`  out  8  committed data byte.
- `o_busy`  out  1  high from the detected START to the detected STOP.

## Operation
- **Input conditioning:** SCL and SDA each pass through a 2-flop synchronizer plus a delay flop. Edge and condition detects use the synchronized value versus the delayed value.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- **Priority per cycle:** reset > STOP > START > SCL edge handling.
  - STOP: go to IDLE, release SDA, drop `o_busy`.
  - START in any state, including repeated start: go to DEV, clear the bit counter, release SDA.
- **Storage:** `mem[0:255]` x 8 and an 8-bit address pointer `ptr`. Memory is not reset; `ptr` resets to 0.
- **Bit handling:** received bits are sampled on SCL rising edges, MSB first. A 3-bit counter counts 0..7.
- **SDA changes:** SDA only changes on detected SCL falling edges. It is never changed while SCL is high.
- **States:**
  - IDLE: ignore all SCL activity until START.
  - DEV: shift 8 bits.
    - On the 8th rising edge, compare `[7:1]` with `DEV_ADDR`.
    - Match: on the next falling edge, drive ACK (`sda_oe`=1) and go to DEV_ACK.
    - Mismatch: go to IDLE with SDA released.
  - DEV_ACK: on the falling edge ending the ACK bit:
    - R/W=0: release SDA, go to ADDR.
    - R/W=1: load `mem[ptr]` into the transmit shift register, drive bit7, go to RD_DAT.
  - ADDR: shift 8 bits into `ptr`, then ACK (ADDR_ACK). After the ACK, release SDA and go to WR_DAT.
  - WR_DAT: shift 8 bits. On the 8th rising edge:
    - write `mem[ptr]`;
    - pulse `o_wr_en` with `o_wr_addr`=`ptr` and `o_wr_dat`=byte;
    - then ACK (WR_ACK), and increment `ptr` (mod 256).
    - After the ACK, return to WR_DAT (sequential write).
  - RD_DAT: on each falling edge, present the next bit; 1 = released, 0 = `sda_oe`=1. After the falling edge following bit0, release SDA and go to RD_ACK.
  - RD_ACK: sample the master bit on the rising edge.
    - 0 (ACK): increment `ptr`, load `mem[ptr+1]`, and drive bit7 on the next falling edge (RD_DAT).
    - 1 (NACK): increment `ptr`, go to IDLE (SDA released, awaiting STOP/START).
- **Random read:** write DEV, ADDR, repeated START, then read DEV. The repeated START sends DEV from the ADDR_ACK→WR_DAT path back to DEV, with `ptr` kept.
- **Partial byte:** a byte interrupted by START/STOP is discarded, with no write and no `ptr` change.

## Timing
- Reset values: `sda_oe`=0 (bus released), `o_wr_en`=0, `o_wr_addr`=0, `o_wr_dat`=0, `o_busy`=0, state IDLE, `ptr`=0. Reset takes effect at the first `sys_clk` edge with `rst_n`=0.
- Pin-to-detect latency: 3 `sys_clk` cycles.
- SDA output change: 1 cycle after the falling-edge detect, so 4 cycles (40 ns) after SCL falls. This satisfies hold at 100–400 kHz.
- `o_wr_en` asserts 1 cycle after the 8th rising-edge detect of a data byte. It lasts exactly 1 cycle. `o_wr_addr`/`o_wr_dat` hold until the next write.
- `o_busy` rises 1 cycle after the START detect and falls 1 cycle after the STOP detect.
- `ptr` wraps 0xFF→0x00 for both writes and reads.
- Read data is sampled from memory when RD_DAT is entered. A write in the same transaction is not possible, so there is no read/write collision.

## Test plan
- **Byte write:** START, 0xA0, 0x12, 0x5A, STOP.
  - ACK=0 on all three 9th clocks.
  - One `o_wr_en` pulse with addr=0x12, dat=0x5A.
  - `mem[0x12]`=0x5A; `o_busy` drops after STOP.
- **Random read:** START, 0xA0, 0x12, repeated START, 0xA1, read 8 bits, NACK, STOP.
  - Master reads 0x5A.
  - SDA released (z) during the NACK clock and after STOP.
- **Address mismatch:** START, 0xA2, 0x00, 0x33, STOP.
  - SDA stays z on every clock, no `o_wr_en`, `mem[0x00]` unchanged.
  - A following 0xA0 transaction is ACKed.
- **Sequential write wrap:** START, 0xA0, 0xFF, 0x11, 0x22, STOP.
  - `o_wr_en` pulses at (0xFF, 0x11), then (0x00, 0x22).
  - Then a random read at 0xFF with master ACK then NACK returns 0x11, 0x22.
- **Current-address read:** after the previous step, START, 0xA1, NACK.
  - Returns `mem[0x01]`; `ptr` ends at 0x02.
- **Reset mid-byte:** `rst_n`=0 for 2 cycles during bit 4 of a data byte.
  - `sda_oe`=0 and all outputs at reset values the next cycle.
  - No `o_wr_en`; the remaining SCL clocks are ignored until a new START.

Source files
------------

// File: rtl/iic_eeprom_slave.sv
`timescale 1ns/1ps
// I2C target modelling a 256 x 8 serial EEPROM with an 8-bit word address.
// Handles byte/sequential write, random, current-address and sequential reads.
module iic_eeprom_slave #(
  parameter logic [6:0] DEV_ADDR = 7'b101_0000
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       iic_scl,
  inout  wire        iic_sda,
  output logic       o_wr_en,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_dat,
  output logic       o_busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_DEV_ACK, S_ADDR, S_ADDR_ACK,
    S_WR_DAT, S_WR_ACK, S_RD_DAT, S_RD_ACK
  } state_t;

  state_t      state, state_d;
  logic [2:0]  scl_pipe, sda_pipe;
  logic        scl_s, scl_q, sda_s, sda_q;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [2:0]  bit_cnt, bit_cnt_d;
  logic [7:0]  shreg, shreg_d, tx, tx_d, ptr, ptr_d;
  logic [7:0]  wr_addr_d, wr_dat_d, rx_byte, rd_byte, rd_next;
  logic        sda_oe, sda_oe_d, busy_d, wr_en_d, rd_more, rd_more_d, mem_we;
  logic [7:0]  mem [256];

  // Synchronizers keep sampling through reset so a reset with SCL high and
  // SDA low does not leave a stale idle value that would look like a START.
  always_ff @(posedge sys_clk) begin
    scl_pipe <= {scl_pipe[1:0], iic_scl};
    sda_pipe <= {sda_pipe[1:0], iic_sda};
  end

  assign scl_s     = scl_pipe[1];
  assign scl_q     = scl_pipe[2];
  assign sda_s     = sda_pipe[1];
  assign sda_q     = sda_pipe[2];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  assign rx_byte = {shreg[6:0], sda_s};
  assign rd_byte = mem[ptr];
  assign rd_next = mem[ptr + 8'd1];
  assign iic_sda = sda_oe ? 1'b0 : 1'bz;

  always_comb begin
    // NOTE: every *_d signal gets its hold value first so no path can infer a latch.
    state_d   = state;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    tx_d      = tx;
    ptr_d     = ptr;
    sda_oe_d  = sda_oe;
    busy_d    = o_busy;
    rd_more_d = rd_more;
    wr_en_d   = 1'b0;
    wr_addr_d = o_wr_addr;
    wr_dat_d  = o_wr_dat;
    mem_we    = 1'b0;

    if (stop_det) begin
      state_d   = S_IDLE;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      rd_more_d = 1'b0;
    end else if (start_det) begin
      state_d   = S_DEV;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
      rd_more_d = 1'b0;
    end else if (scl_rise) begin
      case (state)
        S_DEV, S_ADDR, S_WR_DAT: begin
          shreg_d   = rx_byte;
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (state == S_DEV) begin
              state_d = (rx_byte[7:1] == DEV_ADDR) ? S_DEV_ACK : S_IDLE;
            end else if (state == S_ADDR) begin
              ptr_d   = rx_byte;
              state_d = S_ADDR_ACK;
            end else begin
              mem_we    = 1'b1;
              wr_en_d   = 1'b1;
              wr_addr_d = ptr;
              wr_dat_d  = rx_byte;
              ptr_d     = ptr + 8'd1;
              state_d   = S_WR_ACK;
            end
          end
        end
        S_RD_DAT: bit_cnt_d = bit_cnt + 3'd1;
        S_RD_ACK: begin
          ptr_d = ptr + 8'd1;
          if (!sda_s) begin
            tx_d      = rd_next;
            rd_more_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        // First falling edge starts the ACK, the second one ends it.
        S_DEV_ACK, S_ADDR_ACK, S_WR_ACK: begin
          if (!sda_oe) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            if (state != S_DEV_ACK) begin
              state_d = S_WR_DAT;
            end else if (shreg[0]) begin
              tx_d     = rd_byte;
              sda_oe_d = ~rd_byte[7];
              state_d  = S_RD_DAT;
            end else begin
              state_d = S_ADDR;
            end
          end
        end
        // bit_cnt wraps to 0 once the master has clocked all eight bits.
        S_RD_DAT: begin
          if (bit_cnt == 3'd0) begin
            sda_oe_d = 1'b0;
            state_d  = S_RD_ACK;
          end else begin
            tx_d     = {tx[6:0], 1'b0};
            sda_oe_d = ~tx[6];
          end
        end
        S_RD_ACK: begin
          if (rd_more) begin
            rd_more_d = 1'b0;
            sda_oe_d  = ~tx[7];
            bit_cnt_d = 3'd0;
            state_d   = S_RD_DAT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    // NOTE: state flops use non-blocking assignments so all see pre-edge values.
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      tx        <= 8'h00;
      ptr       <= 8'h00;
      sda_oe    <= 1'b0;
      rd_more   <= 1'b0;
      o_busy    <= 1'b0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= 8'h00;
      o_wr_dat  <= 8'h00;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      shreg     <= shreg_d;
      tx        <= tx_d;
      ptr       <= ptr_d;
      sda_oe    <= sda_oe_d;
      rd_more   <= rd_more_d;
      o_busy    <= busy_d;
      o_wr_en   <= wr_en_d;
      o_wr_addr <= wr_addr_d;
      o_wr_dat  <= wr_dat_d;
    end
  end

  // NOTE: the storage array has no reset; a reset only blocks the write strobe.
  always_ff @(posedge sys_clk) begin
    if (rst_n && mem_we) mem[ptr] <= rx_byte;
  end

endmodule
